// File: rtl/onehot_pkg.sv
// onehot_pkg: shared widths, index type and index-to-one-hot helper for the decoder FIFO path
package onehot_pkg;
  localparam int IDX_W_DEF = 3;
  localparam int DEPTH_DEF = 4;
  typedef logic [IDX_W_DEF-1:0] idx_t;
  function automatic logic [(1<<IDX_W_DEF)-1:0] idx_to_onehot(idx_t idx);
    return {{((1<<IDX_W_DEF)-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/onehot_decoder_fifo_idx_fifo.sv
// idx_fifo: generic sync FIFO with separate count so full and empty are never ambiguous
module idx_fifo import onehot_pkg::*; #(
  parameter int W = IDX_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  always_comb begin
    do_push = push & ~flush & (count_q != CW'(DEPTH));
    do_pop = pop & ~flush & (count_q != '0);
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(do_pop);
    count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  // storage is not reset: contents are only ever observed behind a nonzero count
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/onehot_decoder_fifo.sv
// onehot_decoder_fifo: buffers encoded indices and hands them out as one-hot vectors over valid/ready
module onehot_decoder_fifo import onehot_pkg::*; #(
  parameter int IDX_W = IDX_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int OUT_W = 1 << IDX_W,
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);
  logic [IDX_W-1:0] head;
  idx_fifo #(.W(IDX_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .push(in_valid & in_ready),
    .pop(out_valid & out_ready),
    .wdata(in_idx),
    .rdata(head),
    .count(count)
  );
  // output is masked by count so a reset or flush never exposes stale storage
  always_comb begin
    in_ready = (count < CW'(DEPTH)) & ~flush;
    out_valid = count != '0;
    out_onehot = out_valid ? (OUT_W'(1) << head) : '0;
  end
endmodule

// File: tb/tb_onehot_decoder_fifo.sv
// tb_onehot_decoder_fifo: queue-model scoreboard plus directed literal checks and random traffic
module tb_onehot_decoder_fifo;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [2:0] in_idx = 0;
  logic [7:0] out_onehot;
  logic out_valid, in_ready;
  logic [2:0] count;
  int checks = 0, errors = 0;
  logic [2:0] q[$];
  onehot_decoder_fifo dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_idx(in_idx), .in_valid(in_valid),
    .in_ready(in_ready), .out_onehot(out_onehot), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [2:0] pe(logic [7:0] v);
    logic [2:0] r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) q.delete();
    else if (flush) q.delete();
    else begin
      automatic bit pu = in_valid && q.size() < 4;
      automatic bit po = out_ready && q.size() > 0;
      if (po) void'(q.pop_front());
      if (pu) q.push_back(in_idx);
    end
  logic [7:0] p_oh = 0;
  logic [2:0] p_cnt = 0;
  logic p_val = 0, p_rdy = 0, p_fl = 0, p_iv = 0, p_rst = 0;
  always @(negedge clk) begin
    automatic logic [7:0] e = q.size() ? (8'd1 << q[0]) : 8'd0;
    chk("count", count, q.size());
    chk("out_valid", out_valid, q.size() != 0);
    chk("out_onehot", out_onehot, e);
    chk("in_ready", in_ready, q.size() < 4 && !flush);
    if (rst_n && p_rst && !p_fl) begin
      if (p_val && !p_rdy) chk("stall_stable", out_onehot, p_oh);
      if (p_cnt == 4) chk("no_push_full", count, p_rdy ? 3 : 4);
      if (p_cnt == 0) chk("no_pop_empty", count, p_iv ? 1 : 0);
    end
    if (rst_n && out_valid) chk("onehot_shape", $countones(out_onehot), 1);
    p_oh = out_onehot; p_cnt = count; p_val = out_valid; p_rdy = out_ready;
    p_fl = flush; p_iv = in_valid; p_rst = rst_n;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [2:0] t3 [4] = '{3'd0, 3'd3, 3'd7, 3'd1};
    logic [7:0] o3 [4] = '{8'h01, 8'h08, 8'h80, 8'h02};
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    cyc();
    #3;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_onehot", out_onehot, 8'h00);
    chk("rst_in_ready", in_ready, 1);
    cyc();
    in_idx = 5; in_valid = 1; out_ready = 1;
    cyc();
    in_valid = 0;
    #3;
    chk("t2_onehot", out_onehot, 8'b0010_0000);
    chk("t2_valid", out_valid, 1);
    cyc();
    #3 chk("t2_count", count, 0);
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_idx = t3[i]; in_valid = 1;
      cyc();
    end
    in_idx = 2;
    #3;
    chk("t3_full_count", count, 4);
    chk("t3_full_ready", in_ready, 0);
    cyc();
    in_valid = 0; out_ready = 1;
    #3 chk("t3_no_5th", count, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", out_onehot, o3[i]);
      cyc();
      #3;
    end
    chk("t3_empty", out_valid, 0);
    out_ready = 0;
    in_valid = 1; in_idx = 1; cyc();
    in_idx = 2; cyc();
    in_idx = 6; out_ready = 1;
    #3 chk("t4_count_before", count, 2);
    cyc();
    in_valid = 0;
    #3;
    chk("t4_count_same", count, 2);
    chk("t4_head", out_onehot, 8'h04);
    cyc();
    #3 chk("t4_six_last", out_onehot, 8'h40);
    cyc();
    #3 chk("t4_drained", out_valid, 0);
    out_ready = 0;
    in_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      in_idx = 3'(i);
      cyc();
    end
    in_idx = 4; out_ready = 1; flush = 1;
    #3;
    chk("t5_count3", count, 3);
    chk("t5_ready_flush", in_ready, 0);
    cyc();
    flush = 0; in_valid = 0;
    #3;
    chk("t5_count0", count, 0);
    chk("t5_valid0", out_valid, 0);
    cyc(); cyc();
    #3 chk("t5_no_idx4", out_valid, 0);
    out_ready = 0;
    in_valid = 1; in_idx = 3; cyc();
    in_idx = 5; cyc();
    in_valid = 0;
    #1 rst_n = 0;
    #1;
    chk("t6_async_count", count, 0);
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_onehot", out_onehot, 8'h00);
    cyc();
    #2 rst_n = 1;
    cyc();
    in_idx = 7; in_valid = 1;
    cyc();
    in_valid = 0;
    #3 chk("t6_push7", out_onehot, 8'h80);
    out_ready = 1;
    cyc();
    out_ready = 0;
    in_idx = pe(8'b0101_0101); in_valid = 1;
    cyc();
    in_valid = 0;
    #3 chk("pe_decode", out_onehot, 8'b0100_0000);
    for (int i = 0; i < 800; i++) begin
      cyc();
      in_valid = 1'($urandom_range(0, 1));
      in_idx = 3'($urandom);
      out_ready = (i % 100 < 40) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
    end
    cyc();
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (6) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
